// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter, its caches and the line RAM.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 20;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-port and memory-bus bundles; master is the side that issues requests.
interface mem_port_if #(
    parameter int ADDR_W = mem_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DEF_DATA_W
);
    logic              req;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              err;
    logic [DATA_W-1:0] rdata;

    modport master (output req, rw, addr, wdata, input ready, err, rdata);
    modport slave  (input req, rw, addr, wdata, output ready, err, rdata);
endinterface

interface mem_bus_if #(
    parameter int ADDR_W = mem_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DEF_DATA_W
);
    logic              mem_req;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (output mem_req, mem_rw, mem_addr, mem_wdata, input mem_rdata, mem_ready);
    modport slave  (input mem_req, mem_rw, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-request round-robin pick; a tie goes to the port opposite the last grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic       valid,
    output logic       grant
);

    logic last_grant;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        valid = |req;
        grant = 1'b0;
        if (req == 2'b11) grant = ~last_grant;
        else              grant = req[1];
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst)               last_grant <= 1'b1;
        else if (en && valid)  last_grant <= grant;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide RAM between two requesters: latch a winner, run it, pulse ready or err.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      rst,
    mem_port_if.slave p0,
    mem_port_if.slave p1,
    mem_bus_if.master mem
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next, cnt_inc;
    logic              gnt, gnt_next;
    logic              arb_valid, arb_grant;

    logic              mem_req_q, mem_req_n;
    logic              mem_rw_q, mem_rw_n;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_n;
    logic [1:0]        ready_q, ready_n;
    logic [1:0]        err_q, err_n;
    logic [DATA_W-1:0] rdata_q [2];
    logic [DATA_W-1:0] rdata_n [2];

    rr_arbiter2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .req   ({p1.req, p0.req}),
        .en    (state == IDLE),
        .valid (arb_valid),
        .grant (arb_grant)
    );

    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        gnt_next    = gnt;
        mem_req_n   = mem_req_q;
        mem_rw_n    = mem_rw_q;
        mem_addr_n  = mem_addr_q;
        mem_wdata_n = mem_wdata_q;
        ready_n     = '0;
        err_n       = '0;
        rdata_n[0]  = '0;
        rdata_n[1]  = '0;

        unique case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_next  = BUSY;
                    cnt_next    = '0;
                    gnt_next    = arb_grant;
                    mem_req_n   = 1'b1;
                    mem_rw_n    = arb_grant ? p1.rw    : p0.rw;
                    mem_addr_n  = arb_grant ? p1.addr  : p0.addr;
                    mem_wdata_n = arb_grant ? p1.wdata : p0.wdata;
                end
            end
            BUSY: begin
                // Completion is checked before the watchdog so a last-cycle mem_ready still succeeds.
                if (mem.mem_ready) begin
                    state_next     = DONE;
                    mem_req_n      = 1'b0;
                    ready_n[gnt]   = 1'b1;
                    rdata_n[gnt]   = (mem_rw_q == MEM_WRITE) ? '0 : mem.mem_rdata;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    state_next     = DONE;
                    mem_req_n      = 1'b0;
                    err_n[gnt]     = 1'b1;
                end else begin
                    cnt_next       = cnt_inc;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            mem_req_q   <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ready_q     <= '0;
            err_q       <= '0;
            rdata_q[0]  <= '0;
            rdata_q[1]  <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            mem_req_q   <= mem_req_n;
            mem_rw_q    <= mem_rw_n;
            mem_addr_q  <= mem_addr_n;
            mem_wdata_q <= mem_wdata_n;
            ready_q     <= ready_n;
            err_q       <= err_n;
            rdata_q[0]  <= rdata_n[0];
            rdata_q[1]  <= rdata_n[1];
        end
    end

    // NOTE: the grant id is only read in BUSY, which always follows a load, so it needs no reset.
    always_ff @(posedge clk) begin
        gnt <= gnt_next;
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_rw    = mem_rw_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign p0.ready      = ready_q[0];
    assign p0.err        = err_q[0];
    assign p0.rdata      = rdata_q[0];
    assign p1.ready      = ready_q[1];
    assign p1.err        = err_q[1];
    assign p1.rdata      = rdata_q[1];

endmodule
